// File: rtl/debounce_scan_ctrl.sv
// debounce_scan_ctrl
//   Time-multiplexed debounce controller. A single filter engine visits one
//   channel per sample tick in round-robin order. Each accepted level change
//   is reported as one event on a valid/ready port.
//
//   Optional feature macro: LONG_PRESS_EN (adds per-channel hold counters and
//   a one-shot long-press event; without it evt_long is tied low).
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   sig_in     in   [N_CH]  raw asynchronous inputs
//   sig_out    out  [N_CH]  debounced levels
//   evt_valid  out  event pending
//   evt_ready  in   consumer accepts event
//   evt_ch     out  [CH_W]  channel of pending event
//   evt_level  out  new level (1 = press/rise, 0 = release/fall)
//   evt_long   out  long-press event flag
module debounce_scan_ctrl #(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned PRESCALE = 1000,
  parameter int unsigned SAMPLES  = 3,
  parameter int unsigned LONG_CNT = 64,
  localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] sig_in,
  output logic [N_CH-1:0] sig_out,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [CH_W-1:0] evt_ch,
  output logic            evt_level,
  output logic            evt_long
);

  localparam int unsigned PCNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned CNT_W  = $clog2(SAMPLES + 1);

  // Elaboration-time guard on parameter ranges
  if (N_CH < 2 || PRESCALE == 0 || SAMPLES == 0 || LONG_CNT == 0) begin : g_bad_param
    $error("debounce_scan_ctrl: illegal parameter value");
  end

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_SCAN = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  state_t            state;
  logic [N_CH-1:0]   sync1;
  logic [N_CH-1:0]   syn;
  logic [PCNT_W-1:0] pcnt;
  logic [1:0]        warm;
  logic [CH_W-1:0]   ptr;
  logic [CNT_W-1:0]  cnt [N_CH];

  logic              tick_c;
  logic [CH_W-1:0]   ptr_nxt_c;
  logic [PCNT_W-1:0] pcnt_nxt_c;
  logic              cur_out_c;
  logic              cur_dis_c;
  logic              cur_flip_c;
  logic [CNT_W-1:0]  cur_cnt_c;

  // Prescaler is frozen while an event waits for the consumer
  always_comb begin
    tick_c     = (state != ST_EMIT) && (pcnt == PCNT_W'(PRESCALE - 1));
    pcnt_nxt_c = (pcnt == PCNT_W'(PRESCALE - 1)) ? '0 : pcnt + PCNT_W'(1);
    ptr_nxt_c  = (ptr == CH_W'(N_CH - 1)) ? '0 : ptr + CH_W'(1);
  end

  // Filter decision for the channel currently under the pointer
  always_comb begin
    cur_out_c  = sig_out[ptr];
    cur_dis_c  = syn[ptr] != sig_out[ptr];
    cur_cnt_c  = cnt[ptr];
    cur_flip_c = cur_dis_c && ((32'(cur_cnt_c) + 32'd1) >= SAMPLES);
  end

`ifdef LONG_PRESS_EN
  localparam int unsigned HCNT_W = $clog2(LONG_CNT + 1);

  logic [HCNT_W-1:0] hcnt [N_CH];
  logic [N_CH-1:0]   long_done;
  logic [HCNT_W-1:0] hcnt_nxt_c;
  logic              cur_long_c;

  // Saturating hold count; long event fires once when the limit is reached
  always_comb begin
    hcnt_nxt_c = (32'(hcnt[ptr]) >= LONG_CNT) ? hcnt[ptr] : hcnt[ptr] + HCNT_W'(1);
    cur_long_c = cur_out_c && !cur_flip_c && !long_done[ptr] &&
                 (32'(hcnt_nxt_c) == LONG_CNT);
  end
`endif

  // Input synchronizer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      syn   <= '0;
    end else begin
      sync1 <= sig_in;
      syn   <= sync1;
    end
  end

  // Control FSM, scan engine and registered event port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      pcnt      <= '0;
      warm      <= '0;
      ptr       <= '0;
      sig_out   <= '0;
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      evt_level <= 1'b0;
      evt_long  <= 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) cnt[i] <= '0;
`ifdef LONG_PRESS_EN
      for (int unsigned i = 0; i < N_CH; i++) hcnt[i] <= '0;
      long_done <= '0;
`endif
    end else begin
      if (state != ST_EMIT) pcnt <= pcnt_nxt_c;

      case (state)
        ST_INIT: begin
          if (warm != 2'd3) warm <= warm + 2'd1;
          // Initial levels are adopted silently once the synchronizer is warm
          if (tick_c && warm == 2'd3) begin
            sig_out <= syn;
            for (int unsigned i = 0; i < N_CH; i++) cnt[i] <= '0;
            state   <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          if (tick_c) begin
            ptr <= ptr_nxt_c;
            if (!cur_dis_c) begin
              cnt[ptr] <= '0;
            end else if (!cur_flip_c) begin
              cnt[ptr] <= cur_cnt_c + CNT_W'(1);
            end else begin
              sig_out[ptr] <= ~cur_out_c;
              cnt[ptr]     <= '0;
              evt_ch       <= ptr;
              evt_level    <= ~cur_out_c;
              evt_long     <= 1'b0;
              evt_valid    <= 1'b1;
              state        <= ST_EMIT;
            end
`ifdef LONG_PRESS_EN
            // Falling flip rearms the long-press detector
            if (cur_flip_c && cur_out_c) begin
              hcnt[ptr]      <= '0;
              long_done[ptr] <= 1'b0;
            end else if (!cur_flip_c && cur_out_c) begin
              hcnt[ptr] <= hcnt_nxt_c;
              if (cur_long_c) begin
                long_done[ptr] <= 1'b1;
                evt_ch         <= ptr;
                evt_level      <= 1'b1;
                evt_long       <= 1'b1;
                evt_valid      <= 1'b1;
                state          <= ST_EMIT;
              end
            end
`endif
          end
        end

        ST_EMIT: begin
          if (evt_valid && evt_ready) begin
            evt_valid <= 1'b0;
            state     <= ST_SCAN;
          end
        end

        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// tb_debounce_scan_ctrl
//   Directed and randomized stimulus for debounce_scan_ctrl, checked every
//   cycle against a behavioural model built from the channel visit rules.
//   Honours LONG_PRESS_EN the same way the design does.
module tb_debounce_scan_ctrl;

  localparam int N_CH     = 4;
  localparam int PRESCALE = 4;
  localparam int SAMPLES  = 3;
  localparam int LONG_CNT = 5;

  logic       clk;
  logic       rst_n;
  logic [3:0] sig_in;
  logic [3:0] sig_out;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_ch;
  logic       evt_level;
  logic       evt_long;

  debounce_scan_ctrl #(
    .N_CH    (N_CH),
    .PRESCALE(PRESCALE),
    .SAMPLES (SAMPLES),
    .LONG_CNT(LONG_CNT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sig_in   (sig_in),
    .sig_out  (sig_out),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_ch   (evt_ch),
    .evt_level(evt_level),
    .evt_long (evt_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [3:0] m_s1, m_syn, m_out;
  int         m_phase, m_warm, m_ptr;
  bit         m_scan, m_emit;
  int         m_cnt [4];
  int         m_ev_ch;
  bit         m_ev_level, m_ev_long;
  int         m_raised;
`ifdef LONG_PRESS_EN
  int         m_hcnt [4];
  bit         m_ldone [4];
`endif

  int         dut_raised = 0;
  bit         prev_valid = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_syn = '0; m_out = '0;
    m_phase = 0; m_warm = 0; m_ptr = 0;
    m_scan = 0; m_emit = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
`ifdef LONG_PRESS_EN
    for (int i = 0; i < 4; i++) begin m_hcnt[i] = 0; m_ldone[i] = 0; end
`endif
    prev_valid = 0;
  endtask

  task automatic raise(input int ch, input bit lvl, input bit lng);
    m_emit = 1; m_ev_ch = ch; m_ev_level = lvl; m_ev_long = lng;
    m_raised++;
  endtask

  // One visit of channel p under the debounce rules
  task automatic visit(input int p);
    bit flip;
    flip = 0;
    if (m_syn[p] == m_out[p]) m_cnt[p] = 0;
    else if (m_cnt[p] + 1 < SAMPLES) m_cnt[p]++;
    else flip = 1;
    if (flip) begin
      m_out[p] = ~m_out[p];
      m_cnt[p] = 0;
      raise(p, m_out[p], 0);
`ifdef LONG_PRESS_EN
      if (!m_out[p]) begin m_hcnt[p] = 0; m_ldone[p] = 0; end
`endif
    end
`ifdef LONG_PRESS_EN
    else if (m_out[p]) begin
      if (m_hcnt[p] < LONG_CNT) m_hcnt[p]++;
      if (m_hcnt[p] == LONG_CNT && !m_ldone[p]) begin
        m_ldone[p] = 1;
        raise(p, 1, 1);
      end
    end
`endif
  endtask

  // Advance the model by one rising edge using the inputs held across it
  task automatic model_edge();
    bit tick;
    tick = !m_emit && (m_phase == PRESCALE - 1);
    if (m_emit) begin
      if (evt_ready) m_emit = 0;
    end else begin
      m_phase = (m_phase + 1) % PRESCALE;
    end
    if (tick) begin
      if (!m_scan) begin
        if (m_warm == 3) begin
          m_out = m_syn;
          for (int i = 0; i < 4; i++) m_cnt[i] = 0;
          m_scan = 1;
        end
      end else begin
        visit(m_ptr);
        m_ptr = (m_ptr + 1) % N_CH;
      end
    end
    if (!m_scan && m_warm < 3) m_warm++;
    m_syn = m_s1;
    m_s1  = sig_in;
  endtask

  task automatic check_outputs();
    chk("sig_out", 32'(sig_out), 32'(m_out));
    chk("evt_valid", 32'(evt_valid), 32'(m_emit));
    if (m_emit) begin
      chk("evt_ch", 32'(evt_ch), 32'(m_ev_ch));
      chk("evt_level", 32'(evt_level), 32'(m_ev_level));
      chk("evt_long", 32'(evt_long), 32'(m_ev_long));
    end
`ifndef LONG_PRESS_EN
    chk("evt_long_tied", 32'(evt_long), 32'd0);
`endif
    if (evt_valid && !prev_valid) dut_raised++;
    prev_valid = evt_valid;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_sig_out"}, 32'(sig_out), 32'd0);
    chk({tag, "_evt_valid"}, 32'(evt_valid), 32'd0);
    chk({tag, "_evt_ch"}, 32'(evt_ch), 32'd0);
    chk({tag, "_evt_level"}, 32'(evt_level), 32'd0);
    chk({tag, "_evt_long"}, 32'(evt_long), 32'd0);
  endtask

  // Step until the model has an event pending, bounded
  task automatic wait_event(input string tag);
    for (int i = 0; i < 400 && !m_emit; i++) step();
    chk(tag, 32'(evt_valid), 32'd1);
  endtask

  initial begin
    m_raised  = 0;
    rst_n     = 1'b0;
    sig_in    = 4'b1010;
    evt_ready = 1'b1;
    model_reset();

    // Reset state, then silent adoption of the initial levels
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    run(20);
    chk("adopt_levels", 32'(sig_out), 32'hA);
    chk("adopt_no_event", 32'(m_raised), 32'd0);

    // Stable press on ch2 with consumer ready
    sig_in[2] = 1'b1;
    run(70);
    chk("press_ch2_level", 32'(sig_out[2]), 32'd1);

    // Short pulse on ch1 (two visits) must be filtered out
    sig_in[1] = 1'b0;
    run(32);
    sig_in[1] = 1'b1;
    run(60);
    chk("glitch_ch1_kept", 32'(sig_out[1]), 32'd1);

    // Backpressure: event held while consumer stalls, glitch elsewhere ignored
    evt_ready = 1'b0;
    sig_in[0] = 1'b1;
    wait_event("stall_event_seen");
    sig_in[3] = 1'b0;
    run(20);
    sig_in[3] = 1'b1;
    run(30);
    evt_ready = 1'b1;
    run(40);

    // Reset while an event is pending drops it immediately
    evt_ready = 1'b0;
    sig_in[0] = 1'b0;
    wait_event("pre_reset_event");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(evt_valid), 32'd0);
    chk("async_rst_sig_out", 32'(sig_out), 32'd0);
    model_reset();
    evt_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    run(20);

    // Long hold on ch0, then release
    sig_in[0] = 1'b1;
    run(200);
    sig_in[0] = 1'b0;
    run(80);

    // Randomized inputs and consumer backpressure
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        int b;
        b = int'($urandom_range(0, 3));
        sig_in[b] = ~sig_in[b];
      end
      evt_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    evt_ready = 1'b1;
    run(120);
    chk("event_count", 32'(dut_raised), 32'(m_raised));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
